// File: rtl/prog_stream_loader_if.sv
// Byte-stream handshake plus the SRAM program-write bus driven by the loader.
interface prog_stream_loader_if #(
  parameter int AW = 20
);
  logic          s_valid;
  logic [7:0]    s_data;
  logic          s_last;
  logic          s_ready;
  logic          prog_wen;
  logic [AW-1:0] prog_waddr;
  logic [127:0]  prog_wdata;

  modport master (
    output s_valid, s_data, s_last,
    input  s_ready, prog_wen, prog_waddr, prog_wdata
  );

  modport slave (
    input  s_valid, s_data, s_last,
    output s_ready, prog_wen, prog_waddr, prog_wdata
  );
endinterface

// File: rtl/prog_stream_loader.sv
// Packs a byte stream into 128-bit words and writes them to the SRAM program port
// at consecutive word addresses, holding the CPU in reset while loading.
module prog_stream_loader #(
  parameter int AW    = 20,
  parameter int BYTES = 16
) (
  input  logic                 pll_core_cpuclk,
  input  logic                 prog_rst,
  input  logic                 load_start,
  input  logic [AW-1:0]        load_base,
  prog_stream_loader_if.slave  bus,
  output logic                 cpu_hold_rst,
  output logic                 load_done,
  output logic                 load_err,
  output logic [AW:0]          words_written,
  output logic [7:0]           checksum
);
  localparam int CW = $clog2(BYTES);

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

  state_t                  state;
  logic [AW-1:0]           word_addr;
  logic [CW-1:0]           byte_cnt;
  logic                    last_seen;
  logic [BYTES-1:0][7:0]   buffer;
  logic [BYTES-1:0][7:0]   buf_nxt;

  // Buffer image including the byte being accepted this cycle, so the final
  // byte of a word reaches prog_wdata without an extra cycle.
  for (genvar k = 0; k < BYTES; k++) begin : g_lane
    assign buf_nxt[k] = (byte_cnt == CW'(k)) ? bus.s_data : buffer[k];
  end

  always_ff @(posedge pll_core_cpuclk) begin
    if (prog_rst) begin
      state          <= IDLE;
      word_addr      <= '0;
      byte_cnt       <= '0;
      last_seen      <= 1'b0;
      buffer         <= '0;
      words_written  <= '0;
      checksum       <= '0;
      load_err       <= 1'b0;
      load_done      <= 1'b0;
      cpu_hold_rst   <= 1'b0;
      bus.s_ready    <= 1'b0;
      bus.prog_wen   <= 1'b0;
      bus.prog_waddr <= '0;
      bus.prog_wdata <= '0;
    end else begin
      bus.prog_wen <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (load_start) begin
            state         <= LOAD;
            word_addr     <= load_base;
            byte_cnt      <= '0;
            buffer        <= '0;
            words_written <= '0;
            checksum      <= '0;
            load_err      <= 1'b0;
            load_done     <= 1'b0;
            cpu_hold_rst  <= 1'b1;
            bus.s_ready   <= 1'b1;
          end
        end
        LOAD: begin
          if (bus.s_valid) begin
            buffer   <= buf_nxt;
            checksum <= checksum + bus.s_data;
            byte_cnt <= byte_cnt + 1'b1;
            if (byte_cnt == CW'(BYTES - 1) || bus.s_last) begin
              state          <= WRITE;
              last_seen      <= bus.s_last;
              bus.s_ready    <= 1'b0;
              bus.prog_wen   <= 1'b1;
              bus.prog_waddr <= word_addr;
              bus.prog_wdata <= buf_nxt;
            end
          end
        end
        WRITE: begin
          words_written <= words_written + 1'b1;
          if (last_seen || word_addr == '1) begin
            // Top of the address space ends the load rather than wrapping.
            state        <= DONE;
            load_err     <= ~last_seen;
            load_done    <= 1'b1;
            cpu_hold_rst <= 1'b0;
          end else begin
            state       <= LOAD;
            word_addr   <= word_addr + 1'b1;
            byte_cnt    <= '0;
            buffer      <= '0;
            bus.s_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_prog_stream_loader.sv
// Directed bench for prog_stream_loader: hand-computed write addresses, data,
// counters and checksum for each scenario.
module tb_prog_stream_loader;
  localparam int AW = 20;

  logic          clk = 1'b0;
  logic          prog_rst;
  logic          load_start;
  logic [AW-1:0] load_base;
  logic          cpu_hold_rst;
  logic          load_done;
  logic          load_err;
  logic [AW:0]   words_written;
  logic [7:0]    checksum;

  prog_stream_loader_if #(.AW(AW)) ifc ();

  prog_stream_loader #(.AW(AW), .BYTES(16)) dut (
    .pll_core_cpuclk (clk),
    .prog_rst        (prog_rst),
    .load_start      (load_start),
    .load_base       (load_base),
    .bus             (ifc),
    .cpu_hold_rst    (cpu_hold_rst),
    .load_done       (load_done),
    .load_err        (load_err),
    .words_written   (words_written),
    .checksum        (checksum)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // write monitor
  logic [AW-1:0] wr_addr_q[$];
  logic [127:0]  wr_data_q[$];
  int            rdy_in_wr  = 0;
  int            free_in_wr = 0;

  always @(negedge clk) begin
    if (ifc.prog_wen === 1'b1) begin
      wr_addr_q.push_back(ifc.prog_waddr);
      wr_data_q.push_back(ifc.prog_wdata);
      if (ifc.s_ready !== 1'b0) rdy_in_wr++;
      if (cpu_hold_rst !== 1'b1) free_in_wr++;
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [AW-1:0] base);
    load_base  = base;
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic last, output logic ok);
    ok = 1'b0;
    ifc.s_valid = 1'b1;
    ifc.s_data  = d;
    ifc.s_last  = last;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ifc.s_ready === 1'b1) begin
        ok = 1'b1;
        @(posedge clk); #1;
        break;
      end
    end
    ifc.s_valid = 1'b0;
    ifc.s_last  = 1'b0;
  endtask

  task automatic send_seq(input string tag, input int first, input int n, input int last_idx);
    logic ok;
    for (int i = first; i < first + n; i++) begin
      send(8'(i), (i == last_idx), ok);
      if (!ok) check({tag, "_accept"}, {127'd0, ok}, 128'd1);
    end
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 200; i++) begin
      if (load_done === 1'b1) break;
      @(posedge clk); #1;
    end
    check({tag, "_done"}, {127'd0, load_done}, 128'd1);
  endtask

  localparam logic [127:0] W0 = 128'h0F0E0D0C0B0A09080706050403020100;

  initial begin
    int  base;
    logic ok;
    prog_rst    = 1'b1;
    load_start  = 1'b0;
    load_base   = '0;
    ifc.s_valid = 1'b0;
    ifc.s_data  = '0;
    ifc.s_last  = 1'b0;
    repeat (2) @(posedge clk);
    #1 prog_rst = 1'b0;

    // reset state
    check("rst_s_ready",  {127'd0, ifc.s_ready},  128'd0);
    check("rst_prog_wen", {127'd0, ifc.prog_wen}, 128'd0);
    check("rst_hold",     {127'd0, cpu_hold_rst}, 128'd0);
    check("rst_done",     {127'd0, load_done},    128'd0);
    check("rst_err",      {127'd0, load_err},     128'd0);
    check("rst_words",    128'(words_written),    128'd0);
    check("rst_cs",       128'(checksum),         128'd0);
    check("rst_waddr",    128'(ifc.prog_waddr),   128'd0);
    check("rst_wdata",    ifc.prog_wdata,         128'd0);

    // single word
    base = wr_addr_q.size();
    start(20'h00100);
    check("sw_hold",  {127'd0, cpu_hold_rst}, 128'd1);
    check("sw_ready", {127'd0, ifc.s_ready},  128'd1);
    send_seq("sw", 0, 16, 15);
    wait_done("sw");
    check("sw_nwr",  128'(wr_addr_q.size() - base), 128'd1);
    check("sw_addr", 128'(wr_addr_q[base]), 128'h00100);
    check("sw_data", wr_data_q[base], W0);
    check("sw_words", 128'(words_written), 128'd1);
    check("sw_cs",   128'(checksum), 128'h78);
    check("sw_err",  {127'd0, load_err}, 128'd0);
    check("sw_hold_off", {127'd0, cpu_hold_rst}, 128'd0);

    // partial last word, started from DONE
    base = wr_addr_q.size();
    start(20'h00000);
    send_seq("pw", 0, 20, 19);
    wait_done("pw");
    check("pw_nwr",   128'(wr_addr_q.size() - base), 128'd2);
    check("pw_addr0", 128'(wr_addr_q[base]), 128'd0);
    check("pw_data0", wr_data_q[base], W0);
    check("pw_addr1", 128'(wr_addr_q[base+1]), 128'd1);
    check("pw_data1", wr_data_q[base+1], 128'h13121110);
    check("pw_words", 128'(words_written), 128'd2);
    check("pw_cs",    128'(checksum), 128'hBE);
    check("pw_err",   {127'd0, load_err}, 128'd0);

    // address overflow
    base = wr_addr_q.size();
    start(20'hFFFFF);
    send_seq("ov", 0, 16, -1);
    send(8'h10, 1'b0, ok);
    check("ov_byte17_refused", {127'd0, ok}, 128'd0);
    check("ov_done",  {127'd0, load_done}, 128'd1);
    check("ov_err",   {127'd0, load_err},  128'd1);
    check("ov_ready", {127'd0, ifc.s_ready}, 128'd0);
    check("ov_nwr",   128'(wr_addr_q.size() - base), 128'd1);
    check("ov_addr",  128'(wr_addr_q[base]), 128'hFFFFF);
    check("ov_words", 128'(words_written), 128'd1);
    check("ov_cs",    128'(checksum), 128'h78);

    // backpressure: idle cycle between bytes
    base = wr_addr_q.size();
    start(20'h00200);
    for (int i = 0; i < 16; i++) begin
      send(8'(i), (i == 15), ok);
      if (!ok) check("bp_accept", {127'd0, ok}, 128'd1);
      @(posedge clk); #1;
    end
    wait_done("bp");
    check("bp_nwr",  128'(wr_addr_q.size() - base), 128'd1);
    check("bp_addr", 128'(wr_addr_q[base]), 128'h00200);
    check("bp_data", wr_data_q[base], W0);
    check("bp_cs",   128'(checksum), 128'h78);
    check("ready_during_write", 128'(rdy_in_wr), 128'd0);
    check("hold_during_write",  128'(free_in_wr), 128'd0);

    // load_start mid-load is ignored
    base = wr_addr_q.size();
    start(20'h00300);
    send_seq("ig", 0, 5, -1);
    start(20'h00777);
    check("ig_cs_mid", 128'(checksum), 128'h0A);
    send_seq("ig", 5, 11, 15);
    wait_done("ig");
    check("ig_nwr",   128'(wr_addr_q.size() - base), 128'd1);
    check("ig_addr",  128'(wr_addr_q[base]), 128'h00300);
    check("ig_data",  wr_data_q[base], W0);
    check("ig_words", 128'(words_written), 128'd1);
    check("ig_cs",    128'(checksum), 128'h78);

    // reset mid-load
    base = wr_addr_q.size();
    start(20'h00400);
    send_seq("rm", 0, 7, -1);
    prog_rst = 1'b1;
    @(posedge clk); #1;
    prog_rst = 1'b0;
    check("rm_ready", {127'd0, ifc.s_ready},  128'd0);
    check("rm_hold",  {127'd0, cpu_hold_rst}, 128'd0);
    check("rm_done",  {127'd0, load_done},    128'd0);
    check("rm_words", 128'(words_written),    128'd0);
    check("rm_cs",    128'(checksum),         128'd0);
    repeat (5) @(posedge clk);
    #1;
    check("rm_nwr", 128'(wr_addr_q.size() - base), 128'd0);

    // one-byte image after reset
    base = wr_addr_q.size();
    start(20'h00500);
    send(8'hAA, 1'b1, ok);
    check("ob_accept", {127'd0, ok}, 128'd1);
    wait_done("ob");
    check("ob_nwr",  128'(wr_addr_q.size() - base), 128'd1);
    check("ob_addr", 128'(wr_addr_q[base]), 128'h00500);
    check("ob_data", wr_data_q[base], 128'hAA);
    check("ob_cs",   128'(checksum), 128'hAA);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
